// File: rtl/signed_booth_divider_if.sv
// Divider request/result bundle; master issues operands, slave returns results.
// Handshake: start is taken only while busy=0, results qualified by a one-cycle done.
interface signed_booth_divider_if #(
  parameter int N = 4
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ovf;
  logic           dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, dz
  );
endinterface

// File: rtl/signed_booth_divider.sv
// Signed 2N/N restoring divider, one quotient bit per clock; done 2N+2 edges after accept.
// Busy blocks new starts; results and flags hold until the next done pulse.
module signed_booth_divider #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  signed_booth_divider_if.slave   bus
);
  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nxt;
  logic           load, step, fin, accept;
  logic           pend;
  logic [2*N-1:0] dvd_raw;
  logic [N-1:0]   dvs_raw;
  logic [2*N-1:0] dq;
  logic [N-1:0]   dvs_mag;
  logic [N:0]     prem;
  logic [CW-1:0]  cnt;
  logic           q_neg, r_neg, dz_q;
  logic           busy_q, done_q, ovf_q, dz_out;
  logic [N-1:0]   quo_q, rem_q;
  logic [N:0]     shifted, diff;
  logic [2*N-1:0] qs;
  logic [N-1:0]   rs;
  logic           ovf_c;

  // Operands are captured first; magnitudes are formed on the following edge.
  assign accept = bus.start && (state == IDLE) && !pend;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (pend) begin
        load      = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = FIX;
      end
      FIX: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted = {prem[N-1:0], dq[2*N-1]};
    diff    = shifted - {1'b0, dvs_mag};
    qs      = q_neg ? -dq : dq;
    rs      = r_neg ? -prem[N-1:0] : prem[N-1:0];
    // Representable iff the top N+1 bits of the signed quotient are a pure sign extension.
    ovf_c   = !((&qs[2*N-1:N-1]) || !(|qs[2*N-1:N-1]));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend    <= 1'b0;
      dvd_raw <= '0;
      dvs_raw <= '0;
    end else if (accept) begin
      pend    <= 1'b1;
      dvd_raw <= bus.dividend;
      dvs_raw <= bus.divisor;
    end else if (load) begin
      pend    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dq      <= '0;
      dvs_mag <= '0;
      prem    <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (load) begin
      dq      <= dvd_raw[2*N-1] ? -dvd_raw : dvd_raw;
      dvs_mag <= dvs_raw[N-1] ? -dvs_raw : dvs_raw;
      prem    <= '0;
      cnt     <= '0;
      q_neg   <= dvd_raw[2*N-1] ^ dvs_raw[N-1];
      r_neg   <= dvd_raw[2*N-1];
      dz_q    <= (dvs_raw == '0);
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (!diff[N]) begin
        prem <= diff;
        dq   <= {dq[2*N-2:0], 1'b1};
      end else begin
        prem <= shifted;
        dq   <= {dq[2*N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      dz_out <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= fin;
      if (fin) begin
        quo_q  <= dz_q ? '0 : qs[N-1:0];
        rem_q  <= dz_q ? '0 : rs;
        ovf_q  <= dz_q ? 1'b0 : ovf_c;
        dz_out <= dz_q;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_out;
endmodule
